// File: rtl/stg_3_ex.sv
// EX stage with an EX/ME pipeline register. Single-cycle ALU ops register
// their result on the next edge. MUL (shift-add) and DIVU/REMU (restoring
// division) run one bit per cycle for VALUE_W cycles and stall upstream
// until the final cycle.
module stg_3_ex #(
    parameter int VALUE_W    = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  sys_clock,
    input  logic                  reset_n,
    input  logic                  r_ex_valid,
    input  logic [VALUE_W-1:0]    r_ex_rs1val,
    input  logic [VALUE_W-1:0]    r_ex_rs2val,
    input  logic [VALUE_W-1:0]    r_ex_imm,
    input  logic                  r_ex_ALUSrc,
    input  logic [3:0]            r_ex_aluop,
    input  logic [REG_ADDR_W-1:0] r_ex_rd,
    input  logic                  r_ex_RegWrite,
    input  logic                  r_ex_PrintValue,
    output logic                  stall_ex,
    output logic [VALUE_W-1:0]    r_me_aluout,
    output logic                  r_me_aluzero,
    output logic [REG_ADDR_W-1:0] r_me_rd,
    output logic                  r_me_RegWrite,
    output logic                  r_me_PrintValue
);

    localparam int SH_W  = $clog2(VALUE_W);
    localparam int CNT_W = $clog2(VALUE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    // MUL: multiplicand shifting left. DIV: divisor.
    logic [VALUE_W-1:0]      opa_q;
    // MUL: multiplier shifting right. DIV: dividend shifting out, quotient in.
    logic [VALUE_W-1:0]      opb_q;
    // MUL: partial product. DIV: partial remainder.
    logic [VALUE_W-1:0]      acc_q;
    logic [3:0]              op_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    regwrite_q;
    logic                    print_q;

    logic [VALUE_W-1:0]      opb_mux;
    logic                    is_multi;
    logic [VALUE_W-1:0]      single_res;
    logic [VALUE_W-1:0]      mul_acc_d;
    logic [VALUE_W-1:0]      mul_opa_d;
    logic [VALUE_W-1:0]      mul_opb_d;
    logic [VALUE_W:0]        div_sh;
    logic [VALUE_W:0]        div_diff;
    logic [VALUE_W-1:0]      div_rem_d;
    logic [VALUE_W-1:0]      div_quo_d;
    logic [VALUE_W-1:0]      acc_d;
    logic [VALUE_W-1:0]      opa_d;
    logic [VALUE_W-1:0]      opb_d;
    logic [VALUE_W-1:0]      final_res;

    // Single-cycle ALU; opcodes 9-11 are handled by the iterative engine.
    function automatic logic [VALUE_W-1:0] alu_single(
        input logic [3:0]         op,
        input logic [VALUE_W-1:0] a,
        input logic [VALUE_W-1:0] b
    );
        logic [SH_W-1:0]    shamt;
        logic [VALUE_W-1:0] res;
        shamt = b[SH_W-1:0];
        res   = '0;
        case (op)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a ^ b;
            4'd5:    res = a << shamt;
            4'd6:    res = a >> shamt;
            4'd7:    res = {{(VALUE_W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd8:    res = b;
            default: res = '0;
        endcase
        return res;
    endfunction

    assign opb_mux    = r_ex_ALUSrc ? r_ex_imm : r_ex_rs2val;
    assign is_multi   = (r_ex_aluop == OP_MUL) || (r_ex_aluop == OP_DIVU) ||
                        (r_ex_aluop == OP_REMU);
    assign single_res = alu_single(r_ex_aluop, r_ex_rs1val, opb_mux);

    // One shift-add step: add multiplicand when the current multiplier bit is set.
    assign mul_acc_d  = acc_q + (opb_q[0] ? opa_q : '0);
    assign mul_opa_d  = opa_q << 1;
    assign mul_opb_d  = opb_q >> 1;

    // One restoring-division step; a borrow in the top bit means "restore".
    // A zero divisor never borrows, giving quotient all-ones and remainder = A.
    assign div_sh     = {acc_q, opb_q[VALUE_W-1]};
    assign div_diff   = div_sh - {1'b0, opa_q};
    assign div_rem_d  = div_diff[VALUE_W] ? div_sh[VALUE_W-1:0] : div_diff[VALUE_W-1:0];
    assign div_quo_d  = {opb_q[VALUE_W-2:0], ~div_diff[VALUE_W]};

    assign acc_d      = (state_q == ST_MUL) ? mul_acc_d : div_rem_d;
    assign opa_d      = (state_q == ST_MUL) ? mul_opa_d : opa_q;
    assign opb_d      = (state_q == ST_MUL) ? mul_opb_d : div_quo_d;
    assign final_res  = (state_q == ST_MUL)  ? mul_acc_d :
                        (op_q == OP_REMU)    ? div_rem_d : div_quo_d;

    // Hold upstream while a multi-cycle op starts or is mid-flight; release on its last cycle.
    assign stall_ex   = reset_n &
                        (((state_q == ST_IDLE) & r_ex_valid & is_multi) |
                         ((state_q != ST_IDLE) & (cnt_q != CNT_LAST)));

    // FSM plus EX/ME register: every edge writes either a result or a bubble.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            opa_q           <= '0;
            opb_q           <= '0;
            acc_q           <= '0;
            op_q            <= '0;
            rd_q            <= '0;
            regwrite_q      <= 1'b0;
            print_q         <= 1'b0;
            r_me_aluout     <= '0;
            r_me_aluzero    <= 1'b0;
            r_me_rd         <= '0;
            r_me_RegWrite   <= 1'b0;
            r_me_PrintValue <= 1'b0;
        end else begin
            r_me_aluout     <= '0;
            r_me_aluzero    <= 1'b0;
            r_me_rd         <= '0;
            r_me_RegWrite   <= 1'b0;
            r_me_PrintValue <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (r_ex_valid && is_multi) begin
                        op_q       <= r_ex_aluop;
                        rd_q       <= r_ex_rd;
                        regwrite_q <= r_ex_RegWrite;
                        print_q    <= r_ex_PrintValue;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        if (r_ex_aluop == OP_MUL) begin
                            state_q <= ST_MUL;
                            opa_q   <= r_ex_rs1val;
                            opb_q   <= opb_mux;
                        end else begin
                            state_q <= ST_DIV;
                            opa_q   <= opb_mux;
                            opb_q   <= r_ex_rs1val;
                        end
                    end else if (r_ex_valid) begin
                        r_me_aluout     <= single_res;
                        r_me_aluzero    <= (single_res == '0);
                        r_me_rd         <= r_ex_rd;
                        r_me_RegWrite   <= r_ex_RegWrite;
                        r_me_PrintValue <= r_ex_PrintValue;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q         <= ST_IDLE;
                        cnt_q           <= '0;
                        r_me_aluout     <= final_res;
                        r_me_aluzero    <= (final_res == '0);
                        r_me_rd         <= rd_q;
                        r_me_RegWrite   <= regwrite_q;
                        r_me_PrintValue <= print_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/stg_3_ex.md
STG_3_EX -- requirements
Module: stg_3_ex

Interface
REQ-001 Parameter VALUE_W, default 16, datapath width in bits.
REQ-002 Parameter REG_ADDR_W, default 4, register-address width in bits.
REQ-003 sys_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset is asynchronous and active-low.
REQ-005 r_ex_valid  in  1  instruction present in EX this cycle.
REQ-006 r_ex_rs1val  in  VALUE_W  operand A.
REQ-007 r_ex_rs2val  in  VALUE_W  register operand B.
REQ-008 r_ex_imm  in  VALUE_W  immediate operand B.
REQ-009 r_ex_ALUSrc  in  1  1 selects r_ex_imm as B, 0 selects r_ex_rs2val.
REQ-010 r_ex_aluop  in  4  operation code, encoding per REQ-017.
REQ-011 r_ex_rd  in  REG_ADDR_W  destination register.
REQ-012 r_ex_RegWrite  in  1  write-back enable.
REQ-013 r_ex_PrintValue  in  1  display-result request.
REQ-014 stall_ex  out  1  combinational; upstream holds all r_ex_* stable while it is 1.
REQ-015 r_me_aluout, r_me_aluzero, r_me_rd, r_me_RegWrite, r_me_PrintValue  out  VALUE_W/1/REG_ADDR_W/1/1  registered EX/ME pipeline register.

Function
REQ-016 B SHALL be r_ex_imm when r_ex_ALUSrc=1, else r_ex_rs2val.
REQ-017 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed, result 1/0), 8 PASSB, 9 MUL, 10 DIVU, 11 REMU; 12-15 SHALL give result 0.
REQ-018 ADD/SUB/MUL SHALL wrap modulo 2^VALUE_W; MUL returns the low VALUE_W bits of the unsigned product.
REQ-019 Shifts SHALL use only B[log2(VALUE_W)-1:0] as the shift amount, zero-filled.
REQ-020 Ops 0-8 and 12-15 are single-cycle: with valid=1 in IDLE, the result and sidebands SHALL appear on r_me_* at the next rising edge; stall_ex stays 0.
REQ-021 State machine states: IDLE, MUL, DIV. IDLE->MUL on an edge with valid=1 and op 9; IDLE->DIV with valid=1 and op 10 or 11; an iteration counter is cleared to 0 on entry.
REQ-022 MUL SHALL be iterative shift-add, one bit per cycle; DIV SHALL be unsigned restoring division, one quotient bit per cycle; the counter increments each cycle in MUL/DIV.
REQ-023 On the edge where the counter equals VALUE_W-1, the FSM SHALL load the final result (product, quotient, or remainder) with the captured rd/RegWrite/PrintValue into r_me_*, then return to IDLE.
REQ-024 Multi-cycle latency: result registered VALUE_W+1 edges after the instruction first appears at EX input.
REQ-025 stall_ex = (IDLE and valid and op in {9,10,11}) or (MUL/DIV and counter != VALUE_W-1); upstream advances on the same edge the result is written.
REQ-026 Operands, op, rd, RegWrite, and PrintValue SHALL be captured internally on IDLE->MUL/DIV; inputs during MUL/DIV are ignored.
REQ-027 Every edge that does not write a valid result (valid=0 in IDLE, the entry edge, and non-final MUL/DIV cycles) SHALL load a bubble: aluout=0, aluzero=0, rd=0, RegWrite=0, PrintValue=0.
REQ-028 For a valid result, r_me_aluzero SHALL be 1 iff the result equals 0.
REQ-029 Divide by zero SHALL take the full VALUE_W cycles and give quotient all-ones and remainder = A; no exception is raised.

Reset
REQ-030 On reset_n=0, independent of the clock: state=IDLE, counter=0, captured operands=0, all r_me_* outputs=0, stall_ex=0.
REQ-031 Reset asserted mid MUL/DIV SHALL abandon the operation; no result is written after release.
REQ-032 The first edge after release SHALL treat the inputs as a fresh IDLE-state instruction.

Verification
REQ-033 ADD A=0x7FFF, B=imm 0x0001, ALUSrc=1, rd=3, RegWrite=1 -> next edge: aluout=0x8000, aluzero=0, rd=3, RegWrite=1.
REQ-034 SUB A=5, rs2=5 -> aluout=0, aluzero=1; SLT A=0xFFFF, B=1 -> aluout=1.
REQ-035 MUL A=0x0123, B=0x0100, rd=7 -> stall_ex=1 for 16 cycles; bubbles during the operation; at edge 17 aluout=0x2300, rd=7; stall_ex=0 on that final cycle.
REQ-036 DIVU 100/7 -> quotient 14; REMU 100/7 -> remainder 2; DIVU 0x1234/0 -> 0xFFFF; REMU 0x1234/0 -> 0x1234.
REQ-037 Assert reset_n=0 during the 8th cycle of a MUL -> all outputs 0 immediately, stall_ex=0; after release, an ADD 2+3 -> aluout=5 at the next edge, with no stale MUL result.
REQ-038 Back-to-back: MUL followed by ADD held behind the stall -> the ADD result is registered exactly one edge after the MUL result.
